// File: rtl/attn_norm_multicore.sv
// Row-normalization engine: absolute row sum, exchange with peer cores,
// then per-element restoring division elem*2^scale_shift / global_sum.
module attn_norm_multicore #(
    parameter int unsigned bw_psum     = 20,
    parameter int unsigned col         = 8,
    parameter int unsigned n_peer      = 1,
    parameter int unsigned scale_shift = 8,
    parameter int unsigned sum_bw      = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [bw_psum*col-1:0]    in_data,
    output logic [sum_bw-1:0]         local_sum,
    output logic                      local_sum_valid,
    input  logic [n_peer*sum_bw-1:0]  peer_sum,
    input  logic [n_peer-1:0]         peer_sum_valid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [bw_psum*col-1:0]    out_data,
    output logic                      out_zero,
    output logic                      busy
);

    localparam int unsigned row_bw = bw_psum * col;
    localparam int unsigned q_bw   = bw_psum + scale_shift;
    localparam int unsigned g_bw   = sum_bw + $clog2(n_peer + 1);
    localparam int unsigned s_bw   = sum_bw + 1;
    localparam int unsigned idx_bw = (col > 1) ? $clog2(col) : 1;
    localparam int unsigned cnt_bw = $clog2(q_bw);

    typedef enum logic [2:0] {IDLE, SUM, XCHG, DIV, OUT} state_t;

    state_t                   state, state_next;
    logic [row_bw-1:0]        row;
    logic [sum_bw-1:0]        peer_val [n_peer];
    logic [n_peer-1:0]        captured;
    logic [g_bw-1:0]          divisor;
    logic                     g_zero;
    logic [g_bw-1:0]          rem;
    logic [q_bw-1:0]          dvd;
    logic [idx_bw-1:0]        elem_idx;
    logic [cnt_bw-1:0]        bit_cnt;

    logic signed [s_bw-1:0]   s_sum;
    logic [sum_bw-1:0]        lsum_c;
    logic [g_bw-1:0]          g_sum;
    logic [bw_psum-1:0]       elem_cur;
    logic [g_bw:0]            rem_sh;
    logic                     qbit;
    logic [g_bw-1:0]          rem_new;
    logic [q_bw-1:0]          dvd_new;
    logic [bw_psum-1:0]       quot;
    logic [bw_psum-1:0]       result;
    logic                     elem_done;
    logic                     row_done;
    logic [idx_bw-1:0]        next_idx;
    logic [row_bw-1:0]        row_upd;
    logic [q_bw-1:0]          dvd_first;
    logic [q_bw-1:0]          dvd_next_elem;

    function automatic logic [q_bw-1:0] scaled_mag(input logic [bw_psum-1:0] e);
        logic [bw_psum-1:0] m;
        m = e[bw_psum-1] ? -e : e;
        return q_bw'(m) << scale_shift;
    endfunction

    // Signed row sum and its truncated magnitude
    always_comb begin
        s_sum = '0;
        for (int k = 0; k < col; k++) begin
            s_sum = s_sum + s_bw'($signed(row[k*bw_psum +: bw_psum]));
        end
        lsum_c = sum_bw'(s_sum[s_bw-1] ? -s_sum : s_sum);
    end

    // Global sum of local and captured peer sums
    always_comb begin
        g_sum = g_bw'(local_sum);
        for (int p = 0; p < n_peer; p++) begin
            g_sum = g_sum + g_bw'(peer_val[p]);
        end
    end

    // One restoring-division step plus element bookkeeping
    always_comb begin
        elem_cur      = row[elem_idx*bw_psum +: bw_psum];
        rem_sh        = {rem, dvd[q_bw-1]};
        qbit          = (rem_sh >= {1'b0, divisor});
        rem_new       = qbit ? g_bw'(rem_sh - {1'b0, divisor}) : rem_sh[g_bw-1:0];
        dvd_new       = {dvd[q_bw-2:0], qbit};
        quot          = dvd_new[bw_psum-1:0];
        result        = elem_cur[bw_psum-1] ? -quot : quot;
        elem_done     = (bit_cnt == cnt_bw'(q_bw - 1));
        row_done      = elem_done && (elem_idx == idx_bw'(col - 1));
        next_idx      = elem_idx + idx_bw'(1);
        row_upd       = row;
        row_upd[elem_idx*bw_psum +: bw_psum] = result;
        dvd_first     = scaled_mag(row[bw_psum-1:0]);
        dvd_next_elem = scaled_mag(row[next_idx*bw_psum +: bw_psum]);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SUM;
            SUM:     state_next = XCHG;
            XCHG:    if (&captured) state_next = DIV;
            DIV:     if (g_zero || row_done) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, peer capture and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row             <= '0;
            captured        <= '0;
            divisor         <= '0;
            g_zero          <= 1'b0;
            rem             <= '0;
            dvd             <= '0;
            elem_idx        <= '0;
            bit_cnt         <= '0;
            local_sum       <= '0;
            local_sum_valid <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_zero        <= 1'b0;
            in_ready        <= 1'b1;
            busy            <= 1'b0;
            for (int p = 0; p < n_peer; p++) peer_val[p] <= '0;
        end else begin
            local_sum_valid <= (state == SUM);
            in_ready        <= (state_next == IDLE);
            busy            <= (state_next != IDLE);
            out_valid       <= (state_next == OUT);

            if (state == SUM || state == XCHG) begin
                for (int p = 0; p < n_peer; p++) begin
                    if (peer_sum_valid[p]) begin
                        peer_val[p] <= peer_sum[p*sum_bw +: sum_bw];
                        captured[p] <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        row      <= in_data;
                        captured <= '0;
                    end
                end
                SUM: local_sum <= lsum_c;
                XCHG: begin
                    if (&captured) begin
                        divisor  <= g_sum;
                        g_zero   <= (g_sum == '0);
                        rem      <= '0;
                        dvd      <= dvd_first;
                        elem_idx <= '0;
                        bit_cnt  <= '0;
                    end
                end
                DIV: begin
                    if (g_zero) begin
                        out_data <= '0;
                        out_zero <= 1'b1;
                    end else if (elem_done) begin
                        row      <= row_upd;
                        rem      <= '0;
                        dvd      <= dvd_next_elem;
                        bit_cnt  <= '0;
                        elem_idx <= next_idx;
                        if (row_done) begin
                            out_data <= row_upd;
                            out_zero <= 1'b0;
                        end
                    end else begin
                        rem     <= rem_new;
                        dvd     <= dvd_new;
                        bit_cnt <= bit_cnt + cnt_bw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_norm_multicore.sv
// Scoreboard bench for attn_norm_multicore: directed rows, decoupled monitor.
module tb_attn_norm_multicore;

    localparam int unsigned bw_psum = 20;
    localparam int unsigned col     = 8;
    localparam int unsigned n_peer  = 1;
    localparam int unsigned sum_bw  = 24;
    localparam int unsigned RW      = bw_psum * col;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          zero;
        logic [31:0]   lat;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [RW-1:0]            in_data;
    logic [sum_bw-1:0]        local_sum;
    logic                     local_sum_valid;
    logic [n_peer*sum_bw-1:0] peer_sum;
    logic [n_peer-1:0]        peer_sum_valid;
    logic                     out_valid;
    logic                     out_ready;
    logic [RW-1:0]            out_data;
    logic                     out_zero;
    logic                     busy;

    attn_norm_multicore dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .local_sum       (local_sum),
        .local_sum_valid (local_sum_valid),
        .peer_sum        (peer_sum),
        .peer_sum_valid  (peer_sum_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_zero        (out_zero),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   accept_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [sum_bw-1:0] lsum_q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic prev_lsv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [RW-1:0] fill(input logic [bw_psum-1:0] v);
        logic [RW-1:0] r;
        for (int k = 0; k < col; k++) r[k*bw_psum +: bw_psum] = v;
        return r;
    endfunction

    // Monitor: accept timestamps, local_sum announcements, output rows
    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) accept_cyc = cyc + 1;
            if (local_sum_valid) begin
                check("lsv_single_pulse", RW'(prev_lsv), RW'(0));
                if (lsum_q.size() == 0) fail("local_sum_unexpected");
                else check("local_sum", RW'(local_sum), RW'(lsum_q.pop_front()));
            end
            prev_lsv = local_sum_valid;
            if (out_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) fail("out_unexpected");
                    else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("latency", RW'(cyc - accept_cyc), RW'(cur.lat));
                        check("out_data", out_data, cur.data);
                        check("out_zero", RW'(out_zero), RW'(cur.zero));
                    end
                end else begin
                    check("out_data_stable", out_data, cur.data);
                    check("out_zero_stable", RW'(out_zero), RW'(cur.zero));
                end
                if (out_ready) have_cur = 1'b0;
            end
        end else begin
            prev_lsv = 1'b0;
            have_cur = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            tick();
            n++;
        end
        if (!in_ready) fail("wait_in_ready_timeout");
    endtask

    // Issue a row; d<0 pulses the peer during SUM, else d cycles after XCHG entry
    task automatic issue(input logic [RW-1:0] row, input logic [sum_bw-1:0] peer,
                         input int d, input logic [sum_bw-1:0] lsum);
        wait_ready(600);
        lsum_q.push_back(lsum);
        in_data  = row;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        peer_sum = peer;
        if (d < 0) begin
            peer_sum_valid = 1'b1;
            tick();
            peer_sum_valid = 1'b0;
        end else begin
            tick();
            repeat (d) tick();
            peer_sum_valid = 1'b1;
            tick();
            peer_sum_valid = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [RW-1:0] data, input logic zero, input int lat);
        exp_t e;
        e.data = data;
        e.zero = zero;
        e.lat  = 32'(lat);
        exp_q.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] row2, exp2;
        int n;
        row2 = '0;
        row2[0 +: bw_psum]       = 20'hFFFF9;   // -7
        row2[bw_psum +: bw_psum] = 20'h00003;
        exp2 = '0;
        exp2[0 +: bw_psum]       = 20'hFFFF3;   // -(1792/136) = -13
        exp2[bw_psum +: bw_psum] = 20'h00005;   // 768/136 = 5

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        peer_sum = '0; peer_sum_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", RW'(in_ready), RW'(1));
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_lsv", RW'(local_sum_valid), RW'(0));
        check("rst_local_sum", RW'(local_sum), RW'(0));
        check("rst_out_data", out_data, RW'(0));
        check("rst_out_zero", RW'(out_zero), RW'(0));
        reset = 1'b1;
        tick();

        // all 10s, G=128 -> 20 each
        push_exp(fill(20'd20), 1'b0, 226);
        issue(fill(20'd10), 24'd48, -1, 24'd80);
        // mixed signs, G=136
        push_exp(exp2, 1'b0, 226);
        issue(row2, 24'd132, -1, 24'd4);
        // all -10, G=128 -> -20 each
        push_exp(fill(20'hFFFEC), 1'b0, 226);
        issue(fill(20'hFFFF6), 24'd48, -1, 24'd80);
        // zero divisor
        push_exp(fill(20'd0), 1'b1, 3);
        issue(fill(20'd0), 24'd0, -1, 24'd0);

        // stray peer pulse in IDLE, then the real peer arrives late
        wait_ready(600);
        peer_sum = 24'd99;
        peer_sum_valid = 1'b1;
        tick();
        peer_sum_valid = 1'b0;
        tick();
        push_exp(fill(20'd20), 1'b0, 232);
        issue(fill(20'd10), 24'd48, 5, 24'd80);
        check("late_peer_still_busy", RW'(busy), RW'(1));

        // backpressure in OUT with a competing input row
        wait_ready(600);
        out_ready = 1'b0;
        push_exp(exp2, 1'b0, 226);
        issue(row2, 24'd132, -1, 24'd4);
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        if (!out_valid) fail("wait_out_valid_timeout");
        in_data  = fill(20'd1);
        in_valid = 1'b1;
        repeat (5) begin
            check("bp_in_ready", RW'(in_ready), RW'(0));
            check("bp_out_valid", RW'(out_valid), RW'(1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // reset mid-DIV aborts the row
        wait_ready(600);
        issue(fill(20'd10), 24'd48, -1, 24'd80);
        repeat (50) tick();
        check("mid_div_busy", RW'(busy), RW'(1));
        reset = 1'b0;
        #1;
        check("abort_in_ready", RW'(in_ready), RW'(1));
        check("abort_out_valid", RW'(out_valid), RW'(0));
        check("abort_busy", RW'(busy), RW'(0));
        check("abort_local_sum", RW'(local_sum), RW'(0));
        check("abort_out_data", out_data, RW'(0));
        tick();
        reset = 1'b1;
        tick();

        push_exp(exp2, 1'b0, 226);
        issue(row2, 24'd132, -1, 24'd4);
        wait_ready(600);
        repeat (3) tick();
        check("exp_queue_drained", RW'(exp_q.size()), RW'(0));
        check("lsum_queue_drained", RW'(lsum_q.size()), RW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
